dds_table_loader: RTL and testbench

//   Fills the DDS waveform RAM. Takes samples from a valid/ready stream and

---
 rtl/dds_table_loader.sv | 111 +++++++++++
 tb/tb_dds_table_loader.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dds_table_loader.sv
// Streams one full waveform table into the DDS RAM at sequential addresses,
// keeping a running checksum and sample count of the load.
module dds_table_loader #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_we,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] checksum,
   output logic [ADDR_WIDTH:0]   load_count
);

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  accept;
   logic                  load_begin;
   logic                  last_accept;

   always_ff @(posedge clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   assign accept      = s_valid && s_ready;
   assign last_accept = accept && (ptr_q == {ADDR_WIDTH{1'b1}});
   assign load_begin  = start && (state_q != LOAD);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = LOAD;
         LOAD: begin
            if (abort)            state_d = IDLE;
            else if (last_accept) state_d = DONE;
         end
         DONE: if (start) state_d = LOAD;
         default: state_d = IDLE;
      endcase
   end

   // s_ready depends only on state and abort, never on s_valid
   always_comb begin
      s_ready = (state_q == LOAD) && !abort;
      busy    = (state_q == LOAD);
      done    = (state_q == DONE);
   end

   always_comb begin
      ptr_d      = ptr_q;
      checksum_d = checksum_q;
      count_d    = count_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      data_d     = data_q;
      if (load_begin) begin
         ptr_d      = '0;
         checksum_d = '0;
         count_d    = '0;
      end else if (accept) begin
         ptr_d      = ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
         checksum_d = checksum_q + s_data;
         count_d    = count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
         we_d       = 1'b1;
         addr_d     = ptr_q;
         data_d     = s_data;
      end
   end

   // A reset drops any pending write along with the rest of the state
   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr_q      <= '0;
         checksum_q <= '0;
         count_q    <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
      end else begin
         ptr_q      <= ptr_d;
         checksum_q <= checksum_d;
         count_q    <= count_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
      end
   end

   assign ram_we     = we_q;
   assign ram_addr   = addr_q;
   assign ram_data   = data_q;
   assign checksum   = checksum_q;
   assign load_count = count_q;

endmodule

// File: tb/tb_dds_table_loader.sv
// Directed test of dds_table_loader: full loads, stalled load, abort,
// restart from DONE, reset mid-load and ignored start/s_valid.
module tb_dds_table_loader;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       abort;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;
   logic [7:0] ram_data;
   logic [7:0] ram_addr;
   logic       ram_we;
   logic       busy;
   logic       done;
   logic [7:0] checksum;
   logic [8:0] load_count;

   int n_chk  = 0;
   int n_fail = 0;

   dds_table_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we),
      .busy(busy), .done(done), .checksum(checksum), .load_count(load_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".s_ready"}, 32'(s_ready), 0);
      chk({tag, ".ram_we"}, 32'(ram_we), 0);
      chk({tag, ".ram_addr"}, 32'(ram_addr), 0);
      chk({tag, ".ram_data"}, 32'(ram_data), 0);
      chk({tag, ".busy"}, 32'(busy), 0);
      chk({tag, ".done"}, 32'(done), 0);
      chk({tag, ".checksum"}, 32'(checksum), 0);
      chk({tag, ".load_count"}, 32'(load_count), 0);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b1; s_data = 8'hFF;
      tick(); tick();
      chk_all_zero("reset");

      // Idle: s_valid ignored, abort has no effect
      reset = 1'b1; abort = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("idle.ram_we", 32'(ram_we), 0);
         chk("idle.busy", 32'(busy), 0);
         chk("idle.s_ready", 32'(s_ready), 0);
      end
      abort = 1'b0; s_valid = 1'b0;

      // Test 1: samples 0..255 back to back
      start = 1'b1; tick(); start = 1'b0;
      chk("t1.busy", 32'(busy), 1);
      chk("t1.s_ready", 32'(s_ready), 1);
      chk("t1.ram_we_idle", 32'(ram_we), 0);
      for (int i = 0; i < 256; i++) begin
         s_valid = 1'b1; s_data = 8'(i);
         tick();
         chk("t1.ram_we", 32'(ram_we), 1);
         chk("t1.ram_addr", 32'(ram_addr), 32'(i));
         chk("t1.ram_data", 32'(ram_data), 32'(i));
         if (i < 255) chk("t1.done_early", 32'(done), 0);
      end
      chk("t1.done", 32'(done), 1);
      chk("t1.busy_end", 32'(busy), 0);
      chk("t1.s_ready_end", 32'(s_ready), 0);
      chk("t1.load_count", 32'(load_count), 256);
      chk("t1.checksum", 32'(checksum), 32'h80);
      s_valid = 1'b0;
      tick();
      chk("t1.ram_we_after", 32'(ram_we), 0);
      chk("t1.ram_addr_hold", 32'(ram_addr), 255);
      chk("t1.ram_data_hold", 32'(ram_data), 255);

      // Abort and s_valid in DONE: no effect
      abort = 1'b1; s_valid = 1'b1;
      tick();
      chk("done_abort.done", 32'(done), 1);
      chk("done_abort.ram_we", 32'(ram_we), 0);
      abort = 1'b0; s_valid = 1'b0;

      // Test 4: restart from DONE clears status
      start = 1'b1; tick(); start = 1'b0;
      chk("t4.done", 32'(done), 0);
      chk("t4.load_count", 32'(load_count), 0);
      chk("t4.checksum", 32'(checksum), 0);
      chk("t4.busy", 32'(busy), 1);

      // Test 2: s_valid toggling, constant 0xA5
      s_data = 8'hA5;
      for (int j = 0; j < 512; j++) begin
         s_valid = (j % 2 == 0);
         tick();
         if (j % 2 == 0) begin
            chk("t2.ram_we", 32'(ram_we), 1);
            chk("t2.ram_addr", 32'(ram_addr), 32'(j / 2));
            chk("t2.ram_data", 32'(ram_data), 32'hA5);
         end else begin
            chk("t2.ram_we_gap", 32'(ram_we), 0);
         end
      end
      chk("t2.done", 32'(done), 1);
      chk("t2.checksum", 32'(checksum), 0);
      chk("t2.load_count", 32'(load_count), 256);
      s_valid = 1'b0;

      // Test 3: abort after 10 accepts
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         s_valid = 1'b1; s_data = 8'(10 + i);
         tick();
      end
      abort = 1'b1; s_valid = 1'b1; s_data = 8'hEE;
      #1;
      chk("t3.s_ready", 32'(s_ready), 0);
      chk("t3.ram_we", 32'(ram_we), 1);
      chk("t3.ram_addr", 32'(ram_addr), 9);
      chk("t3.ram_data", 32'(ram_data), 19);
      tick();
      abort = 1'b0; s_valid = 1'b0;
      chk("t3.busy", 32'(busy), 0);
      chk("t3.done", 32'(done), 0);
      chk("t3.ram_we_after", 32'(ram_we), 0);
      chk("t3.load_count", 32'(load_count), 10);
      chk("t3.checksum", 32'(checksum), 32'h91);
      tick();
      chk("t3.idle_busy", 32'(busy), 0);

      // start together with abort in IDLE is honoured
      start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
      chk("start_abort.busy", 32'(busy), 1);
      chk("start_abort.load_count", 32'(load_count), 0);

      // Test 6: start during LOAD is ignored
      s_valid = 1'b1; s_data = 8'h33; tick();
      chk("t6.addr0", 32'(ram_addr), 0);
      start = 1'b1; s_data = 8'h44; tick(); start = 1'b0;
      chk("t6.addr1", 32'(ram_addr), 1);
      chk("t6.count2", 32'(load_count), 2);
      s_data = 8'h55; tick();
      chk("t6.addr2", 32'(ram_addr), 2);
      chk("t6.count3", 32'(load_count), 3);
      chk("t6.checksum", 32'(checksum), 32'hCC);
      chk("t6.ram_we", 32'(ram_we), 1);

      // Test 5: reset on the cycle after an accept
      reset = 1'b0; s_valid = 1'b0;
      tick();
      chk_all_zero("t5");
      reset = 1'b1;
      tick();
      chk("t5.idle_busy", 32'(busy), 0);

      // Fresh load after reset starts at address 0
      start = 1'b1; tick(); start = 1'b0;
      s_valid = 1'b1; s_data = 8'h77; tick(); s_valid = 1'b0;
      chk("post_reset.addr", 32'(ram_addr), 0);
      chk("post_reset.data", 32'(ram_data), 32'h77);
      chk("post_reset.count", 32'(load_count), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
